// File: rtl/cpu_fetch_queue.sv
// cpu_fetch_queue: instruction fetch unit with a single-outstanding bus
// master feeding a circular instruction queue. Each enqueued word carries
// its PC and a wrapping tag; decode pops the head with a valid/ready
// handshake. Branch handling is either stall-until-redirect or
// speculative sequential fetch with flush on redirect.
//
// Ports:
//   i_clock, i_reset    clock, synchronous active-high reset
//   i_stall             blocks issue of new bus requests
//   o_bus_request       fetch request, held until i_bus_ready
//   i_bus_ready         one-cycle completion pulse with read data
//   o_bus_address       fetch address
//   i_bus_rdata         instruction word
//   i_branch, i_pc_next redirect strobe and target
//   o_valid, i_ready    head handshake to decode
//   o_instruction, o_pc, o_tag   head entry fields
//   o_count             queue occupancy
//
// state   | meaning
// IDLE    | no request outstanding; issue when allowed
// REQ     | request outstanding, response will be enqueued
// HOLD    | control transfer fetched, waiting for redirect
// DISCARD | request outstanding but stale, response dropped

module cpu_fetch_queue #(
    parameter int          DEPTH           = 4,
    parameter int          TAG_WIDTH       = 8,
    parameter logic [31:0] RESET_PC        = 32'h0000_0000,
    parameter bit          STALL_ON_BRANCH = 1'b1
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic                     i_stall,
    output logic                     o_bus_request,
    input  logic                     i_bus_ready,
    output logic [31:0]              o_bus_address,
    input  logic [31:0]              i_bus_rdata,
    input  logic                     i_branch,
    input  logic [31:0]              i_pc_next,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [31:0]              o_instruction,
    output logic [31:0]              o_pc,
    output logic [TAG_WIDTH-1:0]     o_tag,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_REQ     = 2'd1;
    localparam logic [1:0] S_HOLD    = 2'd2;
    localparam logic [1:0] S_DISCARD = 2'd3;

    logic [1:0]           r_state;
    logic [31:0]          r_pc;
    logic [TAG_WIDTH-1:0] r_tag;
    logic                 r_bus_request;
    logic [31:0]          r_bus_address;

    logic [31:0]          r_q_instr [DEPTH];
    logic [31:0]          r_q_pc    [DEPTH];
    logic [TAG_WIDTH-1:0] r_q_tag   [DEPTH];
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [CW-1:0]        r_count;

    logic                 w_is_cti;
    logic                 w_can_issue;
    logic                 w_enqueue;
    logic                 w_dequeue;
    logic [TAG_WIDTH-1:0] w_next_tag;

    assign w_is_cti    = (i_bus_rdata[6:0] == 7'b1100011) ||
                         (i_bus_rdata[6:0] == 7'b1101111) ||
                         (i_bus_rdata[6:0] == 7'b1100111);
    // Only one request is ever outstanding, so a free slot at issue time
    // is still free when the response lands.
    assign w_can_issue = !i_stall && (r_count < CW'(DEPTH));
    // Redirect wins over a response arriving in the same cycle.
    assign w_enqueue   = (r_state == S_REQ) && i_bus_ready && !i_branch;
    assign w_dequeue   = (r_count != '0) && i_ready;
    assign w_next_tag  = r_tag + 1'b1;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_tag         <= '0;
            r_bus_request <= 1'b0;
            r_bus_address <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_branch) begin
                        r_pc <= i_pc_next;
                    end else if (w_can_issue) begin
                        r_bus_address <= r_pc;
                        r_bus_request <= 1'b1;
                        r_state       <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (i_branch) begin
                        r_pc <= i_pc_next;
                        if (i_bus_ready) begin
                            r_bus_request <= 1'b0;
                            r_state       <= S_IDLE;
                        end else begin
                            // Bus requests cannot be withdrawn; wait it out.
                            r_state <= S_DISCARD;
                        end
                    end else if (i_bus_ready) begin
                        r_bus_request <= 1'b0;
                        r_tag         <= w_next_tag;
                        r_pc          <= r_pc + 32'd4;
                        r_state       <= (STALL_ON_BRANCH && w_is_cti) ? S_HOLD : S_IDLE;
                    end
                end
                S_HOLD: begin
                    if (i_branch) begin
                        r_pc    <= i_pc_next;
                        r_state <= S_IDLE;
                    end
                end
                S_DISCARD: begin
                    if (i_branch) begin
                        r_pc <= i_pc_next;
                    end
                    if (i_bus_ready) begin
                        r_bus_request <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_q_instr[i] <= '0;
                r_q_pc[i]    <= '0;
                r_q_tag[i]   <= '0;
            end
        end else if (i_branch) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enqueue) begin
                r_q_instr[r_wr_ptr] <= i_bus_rdata;
                r_q_pc[r_wr_ptr]    <= r_pc;
                r_q_tag[r_wr_ptr]   <= w_next_tag;
                r_wr_ptr            <= r_wr_ptr + 1'b1;
            end
            if (w_dequeue) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_enqueue && !w_dequeue) begin
                r_count <= r_count + 1'b1;
            end else if (!w_enqueue && w_dequeue) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    assign o_bus_request = r_bus_request;
    assign o_bus_address = r_bus_address;
    assign o_valid       = (r_count != '0);
    assign o_count       = r_count;
    assign o_instruction = r_q_instr[r_rd_ptr];
    assign o_pc          = r_q_pc[r_rd_ptr];
    assign o_tag         = r_q_tag[r_rd_ptr];

endmodule
